// File: rtl/hella_cache_req_engine_if.sv
// Bundle of command, cache request/response and captured-response signals
// shared between the request engine (master) and its environment (slave).
interface hella_cache_req_engine_if #(
  parameter int NUM_ADDR_BITS = 32,
  parameter int NUM_DATA_BITS = 32,
  parameter int NUM_TAG_BITS  = 7
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [NUM_ADDR_BITS-1:0]   cmd_addr;
  logic [NUM_TAG_BITS-1:0]    cmd_tag;
  logic [4:0]                 cmd_cmd;
  logic [2:0]                 cmd_typ;
  logic [NUM_DATA_BITS-1:0]   cmd_data;
  logic [NUM_DATA_BITS/8-1:0] cmd_mask;
  logic                       clear_kill;

  logic [NUM_ADDR_BITS-1:0]   req_addr;
  logic                       req_ready;
  logic                       req_valid;
  logic [NUM_TAG_BITS-1:0]    req_tag;
  logic [4:0]                 req_cmd;
  logic [2:0]                 req_typ;
  logic [NUM_DATA_BITS-1:0]   req_data;
  logic [NUM_DATA_BITS/8-1:0] req_data_mask;
  logic                       req_kill;

  logic                       rsp_valid;
  logic                       rsp_nack;
  logic [NUM_TAG_BITS-1:0]    rsp_tag;
  logic [2:0]                 rsp_typ;
  logic [NUM_DATA_BITS-1:0]   rsp_data;

  logic                       out_valid;
  logic                       out_nack;
  logic [NUM_TAG_BITS-1:0]    out_tag;
  logic [2:0]                 out_typ;
  logic [NUM_DATA_BITS-1:0]   out_data;

  modport master (
    input  cmd_valid, cmd_addr, cmd_tag, cmd_cmd, cmd_typ, cmd_data, cmd_mask,
           clear_kill, req_ready, rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data,
    output cmd_ready, req_addr, req_valid, req_tag, req_cmd, req_typ, req_data,
           req_data_mask, req_kill, out_valid, out_nack, out_tag, out_typ, out_data
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_tag, cmd_cmd, cmd_typ, cmd_data, cmd_mask,
           clear_kill, req_ready, rsp_valid, rsp_nack, rsp_tag, rsp_typ, rsp_data,
    input  cmd_ready, req_addr, req_valid, req_tag, req_cmd, req_typ, req_data,
           req_data_mask, req_kill, out_valid, out_nack, out_tag, out_typ, out_data
  );
endinterface

// File: rtl/hella_cache_req_engine.sv
// HellaCache request master: one command in flight, store data driven one
// cycle after acceptance, responses/NACKs forwarded upstream with sticky kill.
module hella_cache_req_engine #(
  parameter int NUM_ADDR_BITS = 32,
  parameter int NUM_DATA_BITS = 32,
  parameter int NUM_TAG_BITS  = 7
) (
  input  logic                     clock,
  input  logic                     reset,
  hella_cache_req_engine_if.master io
);
  localparam int NUM_MASK_BITS = NUM_DATA_BITS / 8;

  typedef enum logic {IDLE, REQ} state_t;

  state_t                   state, state_next;
  logic                     accept, handshake;
  logic                     req_valid_q, kill_q;
  logic [NUM_ADDR_BITS-1:0] req_addr_q;
  logic [NUM_TAG_BITS-1:0]  req_tag_q;
  logic [4:0]               req_cmd_q;
  logic [2:0]               req_typ_q;
  logic [NUM_MASK_BITS-1:0] req_mask_q;
  logic [NUM_DATA_BITS-1:0] req_data_q, data_hold_q;
  logic                     out_valid_q, out_nack_q;
  logic [NUM_TAG_BITS-1:0]  out_tag_q;
  logic [2:0]               out_typ_q;
  logic [NUM_DATA_BITS-1:0] out_data_q;

  assign accept    = (state == IDLE) && io.cmd_valid;
  assign handshake = (state == REQ) && io.req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (io.cmd_valid) state_next = REQ;
      REQ:  if (io.req_ready) state_next = IDLE;
    endcase
  end

  // Request fields read as zero whenever no request is outstanding.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_tag_q   <= '0;
      req_cmd_q   <= '0;
      req_typ_q   <= '0;
      req_mask_q  <= '0;
      req_data_q  <= '0;
      data_hold_q <= '0;
    end else if (accept) begin
      req_valid_q <= 1'b1;
      req_addr_q  <= io.cmd_addr;
      req_tag_q   <= io.cmd_tag;
      req_cmd_q   <= io.cmd_cmd;
      req_typ_q   <= io.cmd_typ;
      req_mask_q  <= io.cmd_mask;
      data_hold_q <= io.cmd_data;
    end else if (handshake) begin
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_tag_q   <= '0;
      req_cmd_q   <= '0;
      req_typ_q   <= '0;
      req_mask_q  <= '0;
      req_data_q  <= data_hold_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      out_nack_q  <= 1'b0;
      out_tag_q   <= '0;
      out_typ_q   <= '0;
      out_data_q  <= '0;
    end else if (io.rsp_valid || io.rsp_nack) begin
      out_valid_q <= 1'b1;
      out_nack_q  <= io.rsp_nack;
      out_tag_q   <= io.rsp_tag;
      out_typ_q   <= io.rsp_typ;
      out_data_q  <= io.rsp_data;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  // A new NACK takes priority over any clear in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           kill_q <= 1'b0;
    else if (io.rsp_nack)                 kill_q <= 1'b1;
    else if (io.clear_kill || handshake)  kill_q <= 1'b0;
  end

  assign io.cmd_ready     = (state == IDLE);
  assign io.req_valid     = req_valid_q;
  assign io.req_addr      = req_addr_q;
  assign io.req_tag       = req_tag_q;
  assign io.req_cmd       = req_cmd_q;
  assign io.req_typ       = req_typ_q;
  assign io.req_data      = req_data_q;
  assign io.req_data_mask = req_mask_q;
  assign io.req_kill      = io.rsp_nack | kill_q;
  assign io.out_valid     = out_valid_q;
  assign io.out_nack      = out_nack_q;
  assign io.out_tag       = out_tag_q;
  assign io.out_typ       = out_typ_q;
  assign io.out_data      = out_data_q;
endmodule

// File: tb/tb_hella_cache_req_engine.sv
// Scenario tasks plus a randomized run against a transaction-level model of
// the request engine.
module tb_hella_cache_req_engine;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  hella_cache_req_engine_if #(.NUM_ADDR_BITS(32), .NUM_DATA_BITS(32), .NUM_TAG_BITS(7)) io ();

  hella_cache_req_engine #(.NUM_ADDR_BITS(32), .NUM_DATA_BITS(32), .NUM_TAG_BITS(7)) dut (
    .clock(clock),
    .reset(reset),
    .io   (io)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    io.cmd_valid = 0; io.cmd_addr = 0; io.cmd_tag = 0; io.cmd_cmd = 0; io.cmd_typ = 0;
    io.cmd_data = 0; io.cmd_mask = 0; io.clear_kill = 0; io.req_ready = 0;
    io.rsp_valid = 0; io.rsp_nack = 0; io.rsp_tag = 0; io.rsp_typ = 0; io.rsp_data = 0;
  endtask

  task automatic test_reset();
    logic [143:0] all_out;
    idle_inputs();
    reset = 1'b0;
    step(); step();
    all_out = {io.req_valid, io.req_addr, io.req_tag, io.req_cmd, io.req_typ, io.req_data,
               io.req_data_mask, io.out_valid, io.out_nack, io.out_tag, io.out_typ, io.out_data};
    checks++;
    if (all_out !== '0) begin errors++; $display("[TB] FAIL reset_outputs got %h exp 0", all_out); end
    checks++;
    if (io.cmd_ready !== 1'b1 || io.req_kill !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_ready_kill got ready=%b kill=%b exp 1/0", io.cmd_ready, io.req_kill);
    end
    reset = 1'b1;
    step();
    checks++;
    if (io.req_valid !== 1'b0 || io.cmd_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL post_reset got valid=%b ready=%b exp 0/1", io.req_valid, io.cmd_ready);
    end
  endtask

  task automatic test_read();
    io.cmd_valid = 1; io.cmd_addr = 32'h1000; io.cmd_tag = 7'd5; io.cmd_cmd = 5'd0; io.cmd_typ = 3'd3;
    io.req_ready = 1;
    step();
    io.cmd_valid = 0;
    checks++;
    if ({io.req_valid, io.req_addr, io.req_tag, io.cmd_ready} !== {1'b1, 32'h1000, 7'd5, 1'b0}) begin
      errors++; $display("[TB] FAIL read_req got v=%b a=%h t=%0d rdy=%b exp 1/1000/5/0",
                         io.req_valid, io.req_addr, io.req_tag, io.cmd_ready);
    end
    step();
    checks++;
    if ({io.req_valid, io.req_addr, io.req_tag, io.cmd_ready} !== {1'b0, 32'h0, 7'd0, 1'b1}) begin
      errors++; $display("[TB] FAIL read_done got v=%b a=%h t=%0d rdy=%b exp 0/0/0/1",
                         io.req_valid, io.req_addr, io.req_tag, io.cmd_ready);
    end
    io.req_ready = 0;
  endtask

  task automatic test_write_stall();
    io.cmd_valid = 1; io.cmd_addr = 32'h2004; io.cmd_tag = 7'd9; io.cmd_cmd = 5'd1; io.cmd_typ = 3'd2;
    io.cmd_data = 32'hDEADBEEF; io.cmd_mask = 4'hF; io.req_ready = 0;
    step();
    io.cmd_valid = 0; io.cmd_data = 32'h0; io.cmd_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      io.req_ready = (i == 3);
      checks++;
      if ({io.req_valid, io.req_addr, io.req_tag, io.req_cmd, io.req_typ, io.req_data_mask} !==
          {1'b1, 32'h2004, 7'd9, 5'd1, 3'd2, 4'hF}) begin
        errors++; $display("[TB] FAIL stall_hold[%0d] got v=%b a=%h m=%h exp 1/2004/f",
                           i, io.req_valid, io.req_addr, io.req_data_mask);
      end
      step();
    end
    io.req_ready = 0;
    checks++;
    if (io.req_valid !== 1'b0 || io.req_data !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL write_data got v=%b d=%h exp 0/deadbeef", io.req_valid, io.req_data);
    end
    step();
    checks++;
    if (io.req_data !== 32'hDEADBEEF) begin
      errors++; $display("[TB] FAIL write_data_hold got %h exp deadbeef", io.req_data);
    end
  endtask

  task automatic test_response();
    io.rsp_valid = 1; io.rsp_tag = 7'd5; io.rsp_typ = 3'd3; io.rsp_data = 32'h12345678;
    step();
    io.rsp_valid = 0; io.rsp_data = 32'h0;
    checks++;
    if ({io.out_valid, io.out_nack, io.out_tag, io.out_data} !== {1'b1, 1'b0, 7'd5, 32'h12345678}) begin
      errors++; $display("[TB] FAIL rsp_capture got v=%b n=%b t=%0d d=%h exp 1/0/5/12345678",
                         io.out_valid, io.out_nack, io.out_tag, io.out_data);
    end
    step();
    checks++;
    if (io.out_valid !== 1'b0 || io.out_data !== 32'h12345678) begin
      errors++; $display("[TB] FAIL rsp_pulse got v=%b d=%h exp 0/12345678", io.out_valid, io.out_data);
    end
  endtask

  task automatic test_nack();
    io.rsp_nack = 1; io.rsp_tag = 7'd11;
    #1;
    checks++;
    if (io.req_kill !== 1'b1) begin errors++; $display("[TB] FAIL nack_comb_kill got %b exp 1", io.req_kill); end
    step();
    io.rsp_nack = 0;
    #1;
    checks++;
    if ({io.req_kill, io.out_valid, io.out_nack, io.out_tag} !== {1'b1, 1'b1, 1'b1, 7'd11}) begin
      errors++; $display("[TB] FAIL nack_sticky got k=%b v=%b n=%b t=%0d exp 1/1/1/11",
                         io.req_kill, io.out_valid, io.out_nack, io.out_tag);
    end
    io.clear_kill = 1;
    step();
    io.clear_kill = 0;
    #1;
    checks++;
    if (io.req_kill !== 1'b0) begin errors++; $display("[TB] FAIL nack_clear got %b exp 0", io.req_kill); end
  endtask

  task automatic test_kill_race();
    io.rsp_nack = 1; io.clear_kill = 1;
    step();
    io.rsp_nack = 0; io.clear_kill = 0;
    #1;
    checks++;
    if (io.req_kill !== 1'b1) begin errors++; $display("[TB] FAIL race_set_wins got %b exp 1", io.req_kill); end
    io.cmd_valid = 1; io.cmd_addr = 32'h40; io.req_ready = 1;
    step();
    io.cmd_valid = 0;
    checks++;
    if (io.req_kill !== 1'b1) begin errors++; $display("[TB] FAIL race_before_hs got %b exp 1", io.req_kill); end
    step();
    io.req_ready = 0;
    checks++;
    if (io.req_kill !== 1'b0) begin errors++; $display("[TB] FAIL race_hs_clear got %b exp 0", io.req_kill); end
  endtask

  task automatic test_mid_reset();
    io.cmd_valid = 1; io.cmd_addr = 32'h80; io.cmd_data = 32'h55; io.req_ready = 0;
    step();
    io.cmd_valid = 0;
    checks++;
    if (io.req_valid !== 1'b1) begin errors++; $display("[TB] FAIL midrst_pre got %b exp 1", io.req_valid); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (io.req_valid !== 1'b0 || io.cmd_ready !== 1'b1 || io.req_data !== 32'h0) begin
      errors++; $display("[TB] FAIL midrst_async got v=%b rdy=%b d=%h exp 0/1/0",
                         io.req_valid, io.cmd_ready, io.req_data);
    end
    idle_inputs();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic        m_busy = 0, m_kill = 0, m_out_valid = 0, m_out_nack = 0, hs;
    logic [31:0] m_addr = 0, m_hold = 0, m_req_data = 0, m_out_data = 0;
    logic [6:0]  m_tag = 0, m_out_tag = 0;
    logic [4:0]  m_cmd = 0;
    logic [2:0]  m_typ = 0, m_out_typ = 0;
    logic [3:0]  m_mask = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      io.cmd_valid  = $urandom_range(0, 1);
      io.cmd_addr   = $urandom; io.cmd_tag = 7'($urandom); io.cmd_cmd = 5'($urandom);
      io.cmd_typ    = 3'($urandom); io.cmd_data = $urandom; io.cmd_mask = 4'($urandom);
      io.req_ready  = ($urandom_range(0, 2) != 0);
      io.rsp_valid  = $urandom_range(0, 1);
      io.rsp_nack   = ($urandom_range(0, 4) == 0);
      io.clear_kill = ($urandom_range(0, 3) == 0);
      io.rsp_tag    = 7'($urandom); io.rsp_typ = 3'($urandom); io.rsp_data = $urandom;
      #1;
      checks++;
      if (io.cmd_ready !== !m_busy || io.req_kill !== (io.rsp_nack | m_kill)) begin
        errors++; $display("[TB] FAIL rnd_comb[%0d] got rdy=%b kill=%b exp %b/%b",
                           cyc, io.cmd_ready, io.req_kill, !m_busy, io.rsp_nack | m_kill);
      end
      hs = 0;
      if (!m_busy && io.cmd_valid) begin
        m_busy = 1; m_addr = io.cmd_addr; m_tag = io.cmd_tag; m_cmd = io.cmd_cmd;
        m_typ = io.cmd_typ; m_mask = io.cmd_mask; m_hold = io.cmd_data;
      end else if (m_busy && io.req_ready) begin
        m_busy = 0; m_addr = 0; m_tag = 0; m_cmd = 0; m_typ = 0; m_mask = 0;
        m_req_data = m_hold; hs = 1;
      end
      if (io.rsp_nack) m_kill = 1;
      else if (io.clear_kill || hs) m_kill = 0;
      m_out_valid = io.rsp_valid | io.rsp_nack;
      if (m_out_valid) begin
        m_out_nack = io.rsp_nack; m_out_tag = io.rsp_tag; m_out_typ = io.rsp_typ; m_out_data = io.rsp_data;
      end
      step();
      checks++;
      if ({io.req_valid, io.req_addr, io.req_tag, io.req_cmd, io.req_typ, io.req_data_mask, io.req_data} !==
          {m_busy, m_addr, m_tag, m_cmd, m_typ, m_mask, m_req_data}) begin
        errors++; $display("[TB] FAIL rnd_req[%0d] got v=%b a=%h d=%h exp %b/%h/%h",
                           cyc, io.req_valid, io.req_addr, io.req_data, m_busy, m_addr, m_req_data);
      end
      checks++;
      if ({io.out_valid, io.out_nack, io.out_tag, io.out_typ, io.out_data} !==
          {m_out_valid, m_out_nack, m_out_tag, m_out_typ, m_out_data}) begin
        errors++; $display("[TB] FAIL rnd_out[%0d] got v=%b n=%b t=%0d d=%h exp %b/%b/%0d/%h",
                           cyc, io.out_valid, io.out_nack, io.out_tag, io.out_data,
                           m_out_valid, m_out_nack, m_out_tag, m_out_data);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_stall();
    test_response();
    test_nack();
    test_kill_race();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hella_cache_req_engine.md
Name: hella_cache_req_engine

Overview:
- Synthesizable master for the HellaCache request/response port of a Rocket-style L1 data cache.
- Accepts one command at a time from an upstream command channel and drives the cache request handshake.
- Drives store data one cycle after request acceptance (s1 data convention).
- Captures cache responses and NACKs and forwards them upstream; asserts req_kill after a NACK.

Parameters:
- NUM_ADDR_BITS, 32, width of request address.
- NUM_DATA_BITS, 32, width of request/response data; must be a multiple of 8.
- NUM_TAG_BITS, 7, width of request/response tag.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  upstream command present.
- cmd_ready  out  1  engine can accept a command.
- cmd_addr  in  NUM_ADDR_BITS  request address.
- cmd_tag  in  NUM_TAG_BITS  request tag.
- cmd_cmd  in  5  memory command code (M_XRD, M_XWR, ...).
- cmd_typ  in  3  access size/type.
- cmd_data  in  NUM_DATA_BITS  store data.
- cmd_mask  in  NUM_DATA_BITS/8  byte mask.
- clear_kill  in  1  clears sticky kill.
- req_addr  out  NUM_ADDR_BITS  cache request address.
- req_ready  in  1  cache accepts request.
- req_valid  out  1  cache request valid.
- req_tag  out  NUM_TAG_BITS  cache request tag.
- req_cmd  out  5  cache request command.
- req_typ  out  3  cache request type.
- req_data  out  NUM_DATA_BITS  store data, valid the cycle after acceptance.
- req_data_mask  out  NUM_DATA_BITS/8  byte mask.
- req_kill  out  1  kill of the s1 request.
- rsp_valid  in  1  cache response valid.
- rsp_nack  in  1  cache NACK of the s2 request.
- rsp_tag  in  NUM_TAG_BITS  response tag.
- rsp_typ  in  3  response type.
- rsp_data  in  NUM_DATA_BITS  response data.
- out_valid  out  1  one-cycle pulse: response/NACK captured.
- out_nack  out  1  captured rsp_nack.
- out_tag  out  NUM_TAG_BITS  captured tag.
- out_typ  out  3  captured type.
- out_data  out  NUM_DATA_BITS  captured data.

Behaviour:
- Reset (reset low, asynchronous): every output register is 0, including req_valid, req_addr, req_tag, req_cmd, req_typ, req_data, req_data_mask, kill_q and all out_* outputs. State is IDLE.
- FSM states: IDLE and REQ.
- cmd_ready = (state==IDLE); it is combinational from state only.
- IDLE, cmd_valid=1 at an edge:
  - Register addr/tag/cmd/typ/mask onto the req_* outputs.
  - Set req_valid=1; hold cmd_data internally.
  - Go to REQ.
  - req_valid is first visible in the cycle after acceptance.
- REQ: req_* fields are held stable while req_ready=0.
- REQ, req_ready=1 at an edge (handshake):
  - Clear req_valid, req_addr, req_tag, req_cmd, req_typ, req_data_mask to 0.
  - Load req_data with the held store data.
  - Clear kill_q.
  - Go to IDLE.
- A request held in REQ for one cycle with req_ready=1 completes in that cycle.
- Minimum command-to-command spacing is 2 cycles: accept in IDLE, then handshake in REQ.
- req_data holds its value until the next handshake. It is loaded for reads too; it is don't-care to the cache for reads.
- Response capture, each edge where rsp_valid|rsp_nack=1:
  - out_valid<=1.
  - out_nack<=rsp_nack, out_tag<=rsp_tag, out_typ<=rsp_typ, out_data<=rsp_data.
- When rsp_valid=rsp_nack=0 at an edge: out_valid<=0 and the out_* data fields hold their values.
- There is no backpressure on the out_* channel. Back-to-back responses produce back-to-back pulses.
- Kill logic:
  - kill_q sets on an edge with rsp_nack=1.
  - kill_q clears on an edge with clear_kill=1 or on a request handshake.
  - Simultaneous set and clear: set wins.
  - req_kill = rsp_nack | kill_q (combinational).
- A response arriving while in REQ is captured normally; request and response paths are independent.
- Reset asserted mid-request drops req_valid immediately and returns the FSM to IDLE.

Test Plan:
- Reset low, then release -> all outputs 0, cmd_ready=1, req_kill=0.
- Read: cmd addr=0x1000, tag=5, cmd=0, typ=3, req_ready=1 -> req_valid high exactly 1 cycle with addr 0x1000, tag 5, then 0; cmd_ready low during REQ.
- Write with stall: addr=0x2004, data=0xDEADBEEF, mask=0xF, req_ready low 3 cycles -> req_* fields stable 4 cycles; req_data=0xDEADBEEF in the cycle after the handshake edge, then held.
- Response: rsp_valid=1, tag=5, data=0x12345678 for one cycle -> out_valid pulses once next cycle with tag 5, data 0x12345678, out_nack=0.
- NACK: rsp_nack=1 for one cycle ->
  - req_kill is high that same cycle (combinational) and stays high via kill_q.
  - out_nack=1 pulse.
  - clear_kill=1 -> req_kill=0 next cycle.
- Kill race: rsp_nack and clear_kill high on the same edge -> kill_q=1 afterward; the next request handshake clears it.
